// File: rtl/preemph_framer.sv
// rtl/preemph_framer.sv - pre-emphasis filter and overlapping frame buffer feeding the Hamming stage
module preemph_framer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FRAME_LEN    = 306,
    parameter int HOP_LEN      = 128,
    parameter int BUF_DEPTH    = 512,
    parameter int ALPHA_Q15    = 31785
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SAMPLE_WIDTH-1:0] sample_i,
    input  logic                    sample_valid_i,
    output logic                    overflow_o,
    output logic                    start_o,
    output logic                    valid_to_read_o,
    input  logic                    rd_en_i,
    output logic [SAMPLE_WIDTH-1:0] frame_sample_o,
    input  logic                    done_i,
    output logic [15:0]             frame_count_o
);
    localparam int SW  = SAMPLE_WIDTH;
    localparam int AW  = $clog2(BUF_DEPTH);
    localparam int RIW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [AW:0]            DEPTH_F  = (AW+1)'(BUF_DEPTH);
    localparam logic [AW:0]            FRAME_F  = (AW+1)'(FRAME_LEN);
    localparam logic [AW:0]            HOP_F    = (AW+1)'(HOP_LEN);
    localparam logic [RIW-1:0]         LAST_IDX = RIW'(FRAME_LEN - 1);
    localparam logic signed [2*SW:0]   ALPHA_S  = (2*SW+1)'(ALPHA_Q15);
    localparam logic signed [2*SW:0]   Y_MAX    = (2*SW+1)'((1 << (SW-1)) - 1);
    localparam logic signed [2*SW:0]   Y_MIN    = ~Y_MAX;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_OFFER     = 3'd2;
    localparam logic [2:0] S_WAIT_ACK  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    logic [2:0]            state;
    logic [SW-1:0]         x_prev;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         frame_base;
    logic [AW:0]           fill;
    logic [RIW-1:0]        rd_idx;
    logic [SW-1:0]         rd_data;
    logic [SW-1:0]         mem [BUF_DEPTH];

    logic signed [2*SW:0]  prod;
    logic signed [2*SW:0]  y_full;
    logic [SW-1:0]         y_sat;
    logic                  accept;
    logic                  release_frame;
    logic [AW-1:0]         rd_addr;

    // Full-width difference keeps every bit live; saturation clamps to the sample range.
    always_comb begin
        prod   = $signed({{(SW+1){x_prev[SW-1]}}, x_prev}) * ALPHA_S;
        y_full = $signed({{(SW+1){sample_i[SW-1]}}, sample_i}) - (prod >>> 15);
        if (y_full > Y_MAX) begin
            y_sat = Y_MAX[SW-1:0];
        end else if (y_full < Y_MIN) begin
            y_sat = Y_MIN[SW-1:0];
        end else begin
            y_sat = y_full[SW-1:0];
        end
    end

    assign accept        = sample_valid_i && (fill < DEPTH_F);
    assign release_frame = (state == S_WAIT_DONE) && done_i;
    assign rd_addr       = frame_base + AW'(rd_idx);

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= y_sat;
        end
        if (state == S_FETCH) begin
            rd_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            x_prev          <= '0;
            wr_ptr          <= '0;
            frame_base      <= '0;
            fill            <= '0;
            rd_idx          <= '0;
            overflow_o      <= 1'b0;
            start_o         <= 1'b0;
            valid_to_read_o <= 1'b0;
            frame_sample_o  <= '0;
            frame_count_o   <= '0;
        end else begin
            overflow_o      <= sample_valid_i && !accept;
            start_o         <= 1'b0;
            valid_to_read_o <= 1'b0;
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
                x_prev <= sample_i;
            end
            // Write and release in the same cycle collapse into one net fill update.
            fill <= fill + {{AW{1'b0}}, accept} - (release_frame ? HOP_F : '0);

            case (state)
                S_IDLE: begin
                    if (fill >= FRAME_F) begin
                        start_o <= 1'b1;
                        rd_idx  <= '0;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_OFFER;
                S_OFFER: begin
                    frame_sample_o  <= rd_data;
                    valid_to_read_o <= 1'b1;
                    state           <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (rd_en_i) begin
                        if (rd_idx == LAST_IDX) begin
                            state <= S_WAIT_DONE;
                        end else begin
                            rd_idx <= rd_idx + RIW'(1);
                            state  <= S_FETCH;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (done_i) begin
                        frame_base    <= frame_base + HOP_F[AW-1:0];
                        frame_count_o <= frame_count_o + 16'd1;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_preemph_framer.sv
// tb/tb_preemph_framer.sv - self-checking bench for preemph_framer
module tb_preemph_framer;
    localparam int FL = 306;
    localparam int HL = 128;
    localparam int BD = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sample_i = '0;
    logic        sample_valid_i = 1'b0;
    logic        rd_en_i = 1'b0;
    logic        done_i = 1'b0;
    logic        overflow_o, start_o, valid_to_read_o;
    logic [15:0] frame_sample_o;
    logic [15:0] frame_count_o;

    preemph_framer dut (
        .clk(clk), .rst_n(rst_n), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
        .overflow_o(overflow_o), .start_o(start_o), .valid_to_read_o(valid_to_read_o),
        .rd_en_i(rd_en_i), .frame_sample_o(frame_sample_o), .done_i(done_i),
        .frame_count_o(frame_count_o)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; } vec_t;
    vec_t tbl[9];

    int checks = 0;
    int failures = 0;
    int ystream[$];
    int xprev, mfill, frames;
    int got[FL];
    int n_start = 0, n_valid = 0, n_ovf = 0;

    always @(posedge clk) begin
        #2;
        if (start_o) n_start++;
        if (valid_to_read_o) n_valid++;
        if (overflow_o) n_ovf++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int ref_y(int x, int xp);
        int p, y;
        p = xp * 31785;
        y = x - (p >>> 15);
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(int x);
        sample_i = x[15:0];
        sample_valid_i = 1'b1;
        if (mfill < BD) begin
            ystream.push_back(ref_y(x, xprev));
            xprev = x;
            mfill++;
        end
        @(negedge clk);
        sample_valid_i = 1'b0;
    endtask

    task automatic push_rand(int n);
        for (int i = 0; i < n; i++) push(int'($urandom_range(65535)) - 32768);
    endtask

    task automatic do_reset(int n);
        rst_n = 1'b0;
        idle(n);
        ystream.delete();
        xprev = 0;
        mfill = 0;
        frames = 0;
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_start"}, int'(start_o), 0);
        chk({tag, "_valid"}, int'(valid_to_read_o), 0);
        chk({tag, "_overflow"}, int'(overflow_o), 0);
        chk({tag, "_sample"}, int'(frame_sample_o), 0);
        chk({tag, "_count"}, int'(frame_count_o), 0);
        rst_n = 1'b1;
    endtask

    // mode >= 0: fixed ack delay in cycles; mode < 0: random delay 0..3
    task automatic read_frame(int mode, string tag);
        int base, bad, unstable, first_bad, d, w;
        bit timed_out;
        base = frames * HL;
        bad = 0; unstable = 0; first_bad = -1; timed_out = 0;
        for (int i = 0; i < FL && !timed_out; i++) begin
            w = 0;
            while (!valid_to_read_o && w < 40) begin
                @(negedge clk);
                w++;
            end
            if (!valid_to_read_o) begin
                timed_out = 1;
                chk({tag, "_valid_timeout"}, i, FL);
            end else begin
                got[i] = int'($signed(frame_sample_o));
                if (base + i >= ystream.size() || got[i] != ystream[base + i]) begin
                    if (bad == 0) first_bad = i;
                    bad++;
                end
                d = (mode < 0) ? int'($urandom_range(3)) : mode;
                repeat (d) begin
                    @(negedge clk);
                    if (valid_to_read_o || int'($signed(frame_sample_o)) != got[i]) unstable++;
                end
                rd_en_i = 1'b1;
                @(negedge clk);
                rd_en_i = 1'b0;
            end
        end
        if (!timed_out) begin
            chk($sformatf("%s_data(first_bad_idx=%0d)", tag, first_bad), bad, 0);
            chk({tag, "_stable"}, unstable, 0);
        end
    endtask

    task automatic finish_frame();
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        mfill -= HL;
        frames++;
    endtask

    int s0, v0, f0_128;

    initial begin
        tbl[0] = '{1000, 1000};
        tbl[1] = '{1000, 30};
        tbl[2] = '{32767, 31797};
        tbl[3] = '{-32768, -32768};
        tbl[4] = '{32767, 32767};
        tbl[5] = '{0, -31784};
        tbl[6] = '{-1, -1};
        tbl[7] = '{5, 6};
        tbl[8] = '{-100, -104};

        @(negedge clk);
        do_reset(2);
        check_reset_outputs("reset");

        // first frame: table rows then random fill up to one short of a frame
        for (int r = 0; r < 9; r++) push(tbl[r].x);
        push_rand(FL - 1 - 9);
        idle(3);
        s0 = n_start;
        chk("no_start_at_305", n_start - s0, 0);
        chk("no_valid_before_start", n_valid, 0);
        push_rand(1);
        v0 = n_valid;
        read_frame(0, "frame0");
        chk("start_after_306", n_start - s0, 1);
        chk("frame0_pulses", n_valid - v0, FL);
        for (int r = 0; r < 9; r++) chk($sformatf("preemph_row%0d", r), got[r], tbl[r].y);
        f0_128 = got[HL];
        idle(20);
        chk("quiet_valid", n_valid - v0, FL);
        chk("quiet_start", n_start - s0, 1);
        chk("count_before_done", int'(frame_count_o), 0);
        finish_frame();
        idle(1);
        chk("count_after_done", int'(frame_count_o), 1);

        // overlap: second frame needs HOP more samples, acks stalled 5 cycles
        s0 = n_start;
        push_rand(HL - 1);
        idle(3);
        chk("no_start_before_hop", n_start - s0, 0);
        push_rand(1);
        v0 = n_valid;
        read_frame(5, "frame1");
        chk("start_after_hop", n_start - s0, 1);
        chk("stall_pulses", n_valid - v0, FL);
        chk("overlap_first_sample", got[0], f0_128);
        finish_frame();
        idle(1);
        chk("count_frame1", int'(frame_count_o), 2);

        // back-to-back: enough data buffered during WAIT_DONE for an immediate restart
        push_rand(HL);
        read_frame(-1, "frame2");
        s0 = n_start;
        push_rand(HL);
        idle(2);
        chk("no_start_while_outstanding", n_start - s0, 0);
        finish_frame();
        read_frame(-1, "frame3");
        chk("back_to_back_start", n_start - s0, 1);
        finish_frame();
        idle(1);
        chk("count_frame3", int'(frame_count_o), 4);

        // overflow: no release, buffer fills to depth
        do_reset(1);
        check_reset_outputs("reset2");
        s0 = n_ovf;
        push_rand(BD);
        idle(2);
        chk("no_overflow_at_512", n_ovf - s0, 0);
        push_rand(1);
        idle(2);
        chk("overflow_on_513", n_ovf - s0, 1);
        push_rand(1);
        idle(2);
        chk("overflow_on_514", n_ovf - s0, 2);

        // reset mid-frame, then a fresh frame from an empty buffer
        do_reset(1);
        check_reset_outputs("midframe_reset");
        s0 = n_start;
        push_rand(FL - 1);
        idle(3);
        chk("post_reset_no_start", n_start - s0, 0);
        push_rand(1);
        read_frame(0, "frame_after_reset");
        chk("post_reset_start", n_start - s0, 1);
        finish_frame();
        idle(1);
        chk("post_reset_count", int'(frame_count_o), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
